// File: rtl/decode_seq_pkg.sv
// Shared opcodes, writeback selects and FSM state encodings for the sequencer.
// Paired opcodes compare ir[15:12]; ir[11] then selects the 2-word immediate form.
package decode_seq_pkg;

    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [3:0] OPC_LSx  = 4'b0001;
    localparam logic [3:0] OPC_ADD  = 4'b0010;
    localparam logic [3:0] OPC_SUB  = 4'b0011;
    localparam logic [3:0] OPC_MOV  = 4'b0100;
    localparam logic [3:0] OPC_MAS  = 4'b0101;
    localparam logic [4:0] OPC_JMPR = 5'b01100;
    localparam logic [4:0] OPC_JMPI = 5'b01101;
    localparam logic [4:0] OPC_RTN  = 5'b01110;
    localparam logic [4:0] OPC_CALL = 5'b01111;
    localparam logic [3:0] OPC_CMP  = 4'b1000;
    localparam logic [4:0] OPC_STP  = 5'b11111;

    localparam logic [2:0] WB_RS  = 3'b000;
    localparam logic [2:0] WB_PC  = 3'b001;
    localparam logic [2:0] WB_N   = 3'b010;
    localparam logic [2:0] WB_ALU = 3'b100;
    localparam logic [2:0] WB_MAS = 3'b101;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       rd_wen;
        logic       push_up;
        logic       move_fp;
        logic [2:0] wb_sel;
    } strobe_t;

endpackage

// File: rtl/decode_seq_nextpc.sv
// Combinational decode of one instruction word: next pc, halt request and
// the register-file / stack strobes it implies.
module decode_seq_nextpc
    import decode_seq_pkg::*;
#(
    parameter int W      = 16,
    parameter int SKIP_W = 2
) (
    input  logic [W-1:0] ir,
    input  logic [W-1:0] nr,
    input  logic [W-1:0] pc,
    input  logic [W-1:0] rddata,
    input  logic         cond,
    output logic [W-1:0] next_pc,
    output logic         halt_req,
    output logic         rd_wen,
    output logic         push_up,
    output logic         move_fp,
    output logic [2:0]   wb_sel
);

    logic [4:0]   op;
    logic [3:0]   grp;
    logic [W-1:0] pc1;
    logic [W-1:0] seq;
    logic [W-1:0] skip;
    logic         unused_ir;
    strobe_t      s;

    assign op        = ir[15:11];
    assign grp       = ir[15:12];
    assign pc1       = pc + W'(1);
    assign seq       = pc1 + W'(ir[11]);
    assign skip      = seq + W'(ir[SKIP_W-1:0]);
    assign unused_ir = ^ir;

    always_comb begin
        s        = '0;
        next_pc  = pc1;
        halt_req = 1'b0;
        unique case (1'b1)
            op == OPC_NOP: next_pc = pc1;
            grp == OPC_LSx,
            grp == OPC_ADD,
            grp == OPC_SUB: begin
                next_pc  = seq;
                s.rd_wen = 1'b1;
                s.wb_sel = WB_ALU;
            end
            grp == OPC_MOV: begin
                next_pc  = seq;
                s.rd_wen = 1'b1;
                s.wb_sel = ir[11] ? WB_N : WB_RS;
            end
            grp == OPC_MAS: begin
                next_pc  = seq;
                s.rd_wen = 1'b1;
                s.wb_sel = WB_MAS;
            end
            op == OPC_JMPR: next_pc = rddata;
            op == OPC_JMPI: next_pc = nr;
            op == OPC_CALL: begin
                next_pc   = nr;
                s.push_up = 1'b1;
                s.rd_wen  = 1'b1;
                s.wb_sel  = WB_PC;
            end
            op == OPC_RTN: begin
                next_pc   = rddata;
                s.move_fp = 1'b1;
                s.push_up = 1'b1;
            end
            grp == OPC_CMP: next_pc = cond ? skip : pc1;
            // STP and every unassigned opcode park the core on this pc
            default: begin
                next_pc  = pc;
                halt_req = 1'b1;
            end
        endcase
    end

    assign rd_wen  = s.rd_wen;
    assign push_up = s.push_up;
    assign move_fp = s.move_fp;
    assign wb_sel  = s.wb_sel;

endmodule

// File: rtl/decode_seq.sv
// Instruction sequencer: owns pc, runs the FETCH/EXEC/HALT loop and
// registers the one-cycle strobes produced by the decoder.
module decode_seq
    import decode_seq_pkg::*;
#(
    parameter int           W        = 16,
    parameter int           SKIP_W   = 2,
    parameter logic [W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] instr,
    input  logic [W-1:0] N,
    input  logic         mem_valid,
    input  logic         cond,
    input  logic [W-1:0] rddata,
    input  logic         run,
    output logic         fetch_req,
    output logic [W-1:0] instr_addr1,
    output logic [W-1:0] instr_addr2,
    output logic [W-1:0] pc,
    output logic         rd_wen,
    output logic         push_up,
    output logic         move_fp,
    output logic [2:0]   wb_sel,
    output logic         halted
);

    state_t       state;
    logic [W-1:0] pc_q;
    logic [W-1:0] ir;
    logic [W-1:0] nr;
    logic         fetch_q;
    logic         halted_q;
    strobe_t      stb_q;
    strobe_t      dec_stb;
    logic [W-1:0] dec_ir;
    logic [W-1:0] next_pc;
    logic         halt_req;

    // Strobes are captured as EXEC is entered, so decode the word on the bus
    // during FETCH and the latched word during EXEC.
    assign dec_ir = (state == ST_EXEC) ? ir : instr;

    decode_seq_nextpc #(
        .W      (W),
        .SKIP_W (SKIP_W)
    ) u_nextpc (
        .ir       (dec_ir),
        .nr       (nr),
        .pc       (pc_q),
        .rddata   (rddata),
        .cond     (cond),
        .next_pc  (next_pc),
        .halt_req (halt_req),
        .rd_wen   (dec_stb.rd_wen),
        .push_up  (dec_stb.push_up),
        .move_fp  (dec_stb.move_fp),
        .wb_sel   (dec_stb.wb_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir       <= '0;
            nr       <= '0;
            fetch_q  <= 1'b0;
            halted_q <= 1'b0;
            stb_q    <= '0;
        end else begin
            stb_q <= '0;
            unique case (state)
                ST_FETCH: begin
                    fetch_q <= 1'b1;
                    if (fetch_q && mem_valid) begin
                        ir      <= instr;
                        nr      <= N;
                        fetch_q <= 1'b0;
                        stb_q   <= dec_stb;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (halt_req) begin
                        halted_q <= 1'b1;
                        state    <= ST_HALT;
                    end else begin
                        pc_q    <= next_pc;
                        fetch_q <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (run) begin
                        pc_q     <= pc_q + W'(1);
                        halted_q <= 1'b0;
                        fetch_q  <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign fetch_req   = fetch_q;
    assign pc          = pc_q;
    assign instr_addr1 = pc_q;
    assign instr_addr2 = pc_q + W'(1);
    assign rd_wen      = stb_q.rd_wen;
    assign push_up     = stb_q.push_up;
    assign move_fp     = stb_q.move_fp;
    assign wb_sel      = stb_q.wb_sel;
    assign halted      = halted_q;

endmodule

// File: tb/tb_decode_seq.sv
// Directed bench for decode_seq: walks pc through each instruction class,
// wrap-around, halt/run and reset corner cases with hand-computed values.
module tb_decode_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic [15:0] N = '0;
    logic        mem_valid = 1'b0;
    logic        cond = 1'b0;
    logic [15:0] rddata = '0;
    logic        run = 1'b0;
    logic        fetch_req;
    logic [15:0] instr_addr1;
    logic [15:0] instr_addr2;
    logic [15:0] pc;
    logic        rd_wen;
    logic        push_up;
    logic        move_fp;
    logic [2:0]  wb_sel;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    decode_seq dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .N           (N),
        .mem_valid   (mem_valid),
        .cond        (cond),
        .rddata      (rddata),
        .run         (run),
        .fetch_req   (fetch_req),
        .instr_addr1 (instr_addr1),
        .instr_addr2 (instr_addr2),
        .pc          (pc),
        .rd_wen      (rd_wen),
        .push_up     (push_up),
        .move_fp     (move_fp),
        .wb_sel      (wb_sel),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One fetch+exec; stb = {rd_wen,push_up,move_fp}
    task automatic step(input string tag, input logic [15:0] w,
                        input logic [15:0] n, input logic c,
                        input logic [15:0] rd, input logic [15:0] exp_pc,
                        input logic [2:0] stb, input logic [2:0] wb);
        for (int i = 0; i < 20 && !fetch_req; i++) @(negedge clk);
        check({tag, ".fetch"}, 32'(fetch_req), 32'd1);
        instr     = w;
        N         = n;
        cond      = c;
        rddata    = rd;
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        check({tag, ".stb"}, 32'({rd_wen, push_up, move_fp}), 32'(stb));
        if (stb[2]) check({tag, ".wb"}, 32'(wb_sel), 32'(wb));
        @(negedge clk);
        check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        check({tag, ".clr"}, 32'({rd_wen, push_up, move_fp}), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst.pc", 32'(pc), 32'h0);
        check("rst.fetch", 32'(fetch_req), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.stb", 32'({rd_wen, push_up, move_fp, wb_sel}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst.addr2", 32'(instr_addr2), 32'h1);

        step("nop", 16'h0000, 16'h0, 0, 16'h0, 16'h0001, 3'b000, 3'b000);
        check("nop.addr1", 32'(instr_addr1), 32'h0001);
        step("jmpi10", 16'h6800, 16'h0010, 0, 16'h0, 16'h0010, 3'b000, 3'b000);
        step("addi", 16'h2800, 16'h1234, 0, 16'h0, 16'h0012, 3'b100, 3'b100);
        check("addi.addr1", 32'(instr_addr1), 32'h0012);
        check("addi.addr2", 32'(instr_addr2), 32'h0013);
        step("jmpi20", 16'h6800, 16'h0020, 0, 16'h0, 16'h0020, 3'b000, 3'b000);
        step("cmp1", 16'h8003, 16'h0, 1, 16'h0, 16'h0024, 3'b000, 3'b000);
        step("jmpi20b", 16'h6800, 16'h0020, 0, 16'h0, 16'h0020, 3'b000, 3'b000);
        step("cmp0", 16'h8003, 16'h0, 0, 16'h0, 16'h0021, 3'b000, 3'b000);
        step("jmpi40", 16'h6800, 16'h0040, 0, 16'h0, 16'h0040, 3'b000, 3'b000);
        step("call", 16'h7800, 16'h0100, 0, 16'h0, 16'h0100, 3'b110, 3'b001);
        step("rtn", 16'h7000, 16'h0, 0, 16'h0041, 16'h0041, 3'b011, 3'b000);
        step("movi", 16'h4800, 16'h5555, 0, 16'h0, 16'h0043, 3'b100, 3'b010);
        step("movr", 16'h4000, 16'h0, 0, 16'h0, 16'h0044, 3'b100, 3'b000);
        step("mas", 16'h5000, 16'h0, 0, 16'h0, 16'h0045, 3'b100, 3'b101);
        step("jmpr", 16'h6000, 16'h0, 0, 16'hFFFF, 16'hFFFF, 3'b000, 3'b000);
        check("wrap.addr2", 32'(instr_addr2), 32'h0000);
        step("nopwrap", 16'h0000, 16'h0, 0, 16'h0, 16'h0000, 3'b000, 3'b000);
        step("jmpi50", 16'h6800, 16'h0050, 0, 16'h0, 16'h0050, 3'b000, 3'b000);
        step("stp", 16'hF800, 16'h0, 0, 16'h0, 16'h0050, 3'b000, 3'b000);
        check("stp.halted", 32'(halted), 32'd1);
        check("stp.fetch", 32'(fetch_req), 32'd0);

        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        check("halt.mv.pc", 32'(pc), 32'h0050);
        check("halt.mv.halted", 32'(halted), 32'd1);

        reset = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        check("rstrun.pc", 32'(pc), 32'h0);
        check("rstrun.halted", 32'(halted), 32'd0);
        check("rstrun.fetch", 32'(fetch_req), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run = 1'b0;
        check("runfetch.pc", 32'(pc), 32'h0);

        step("jmpi50b", 16'h6800, 16'h0050, 0, 16'h0, 16'h0050, 3'b000, 3'b000);
        step("stp2", 16'hF800, 16'h0, 0, 16'h0, 16'h0050, 3'b000, 3'b000);
        check("stp2.halted", 32'(halted), 32'd1);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("run.halted", 32'(halted), 32'd0);
        check("run.pc", 32'(pc), 32'h0051);
        check("run.fetch", 32'(fetch_req), 32'd1);
        check("run.addr1", 32'(instr_addr1), 32'h0051);

        step("undef", 16'h0800, 16'h0, 0, 16'h0, 16'h0051, 3'b000, 3'b000);
        check("undef.halted", 32'(halted), 32'd1);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("undef.run.pc", 32'(pc), 32'h0052);

        instr     = 16'h6800;
        N         = 16'h1234;
        mem_valid = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstexec.pc", 32'(pc), 32'h0);
        check("rstexec.stb", 32'({rd_wen, push_up, move_fp}), 32'd0);
        check("rstexec.fetch", 32'(fetch_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
